// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared types and default widths for the framebuffer port arbiter
package fb_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_HOST = 2'd2
  } req_tag_t;

  localparam int FB_AW = 17;
  localparam int FB_DW = 12;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - VGA fetch, host command and framebuffer RAM signals of the port arbiter
interface fb_port_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int AW = FB_AW,
  parameter int DW = FB_DW
);

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          host_starved;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr,
    output vga_gnt, vga_rdata, vga_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid, host_starved,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_gnt, vga_rdata, vga_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid, host_starved,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/fb_arb_tag_pipe.sv
// rtl/fb_arb_tag_pipe.sv - delays the read-owner tag so it lines up with RAM read data
module fb_arb_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_tag_t tag_in,
  output req_tag_t tag_out
);

  req_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - shares one framebuffer RAM between VGA scan-out and the host port
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fb_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starve_hit;
  logic          vga_gnt_c;
  logic          host_gnt_c;

  logic          cmd_en;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  req_tag_t      cmd_tag;
  req_tag_t      next_tag;
  req_tag_t      ret_tag;

  logic          vga_rvalid_q;
  logic [DW-1:0] vga_rdata_q;
  logic          host_rvalid_q;
  logic [DW-1:0] host_rdata_q;

  // Grants are masked while reset is held so every output reads 0 during reset.
  assign starve_hit = (starve_cnt == STARVE_LIM);
  assign host_gnt_c = rst_n && bus.host_req && (!bus.vga_req || starve_hit);
  assign vga_gnt_c  = rst_n && bus.vga_req && !(bus.host_req && starve_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (host_gnt_c || !bus.host_req) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    next_tag = TAG_NONE;
    if (vga_gnt_c) begin
      next_tag = TAG_VGA;
    end else if (host_gnt_c && !bus.host_we) begin
      next_tag = TAG_HOST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_en    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_tag   <= TAG_NONE;
    end else begin
      cmd_en    <= vga_gnt_c || host_gnt_c;
      cmd_we    <= host_gnt_c && bus.host_we;
      cmd_addr  <= host_gnt_c ? bus.host_addr : (vga_gnt_c ? bus.vga_addr : '0);
      cmd_wdata <= host_gnt_c ? bus.host_wdata : '0;
      cmd_tag   <= next_tag;
    end
  end

  // The tag enters alongside mem_en and emerges in the cycle mem_rdata is valid.
  fb_arb_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (cmd_tag),
    .tag_out (ret_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rvalid_q  <= 1'b0;
      vga_rdata_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      vga_rvalid_q  <= (ret_tag == TAG_VGA);
      host_rvalid_q <= (ret_tag == TAG_HOST);
      if (ret_tag == TAG_VGA) begin
        vga_rdata_q <= bus.mem_rdata;
      end
      if (ret_tag == TAG_HOST) begin
        host_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.vga_gnt      = vga_gnt_c;
  assign bus.host_gnt     = host_gnt_c;
  assign bus.host_starved = host_gnt_c && bus.vga_req;
  assign bus.mem_en       = cmd_en;
  assign bus.mem_we       = cmd_we;
  assign bus.mem_addr     = cmd_addr;
  assign bus.mem_wdata    = cmd_wdata;
  assign bus.vga_rvalid   = vga_rvalid_q;
  assign bus.vga_rdata    = vga_rdata_q;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.host_rdata   = host_rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - scoreboard bench for fb_port_arbiter with a latency-modelled RAM
module tb_fb_port_arbiter;
  import fb_arb_pkg::*;

  localparam int AW         = FB_AW;
  localparam int DW         = FB_DW;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  fb_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [DW-1:0] seed_val(input int a);
    if (a == 'h10) return 12'hABC;
    return DW'((a * 37 + 5) & 'hFFF);
  endfunction

  // RAM fixture: contents default to seed_val, reads appear MEM_LAT cycles after mem_en.
  logic [DW-1:0] ram [int];
  logic [DW-1:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    for (int k = MEM_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= ram.exists(int'(bus.mem_addr)) ? ram[int'(bus.mem_addr)] : seed_val(int'(bus.mem_addr));
    if (bus.mem_en && bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wdata;
  end
  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  typedef struct {
    bit            vg, hg, st, en, we, zero;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cyc_exp_t;

  typedef struct {
    bit            host;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  cyc_exp_t      exp_q [$];
  rd_exp_t       rd_q [$];
  logic [DW-1:0] m_mem [int];
  cyc_exp_t      prev_cmd;
  int            m_wait;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  bit            v_pend, h_pend, h_w;
  logic [AW-1:0] v_a, h_a;
  logic [DW-1:0] h_d;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : seed_val(int'(a));
  endfunction

  function automatic logic [AW-1:0] r_addr();
    return ($urandom_range(0, 9) == 0) ? AW'('h1FFFF) : AW'($urandom_range(0, 15));
  endfunction

  task automatic arm_v(input logic [AW-1:0] a);
    v_pend = 1'b1; v_a = a;
  endtask

  task automatic arm_h(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_pend = 1'b1; h_w = w; h_a = a; h_d = d;
  endtask

  task automatic clear_cmd();
    prev_cmd.vg = 0; prev_cmd.hg = 0; prev_cmd.st = 0; prev_cmd.en = 0;
    prev_cmd.we = 0; prev_cmd.zero = 0; prev_cmd.addr = '0; prev_cmd.wdata = '0;
  endtask

  // One clock of stimulus: drive pending requests and predict this cycle's grants and next cycle's RAM command.
  task automatic tick();
    cyc_exp_t e;
    bit ev, eh;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.vga_req = v_pend; bus.vga_addr = v_a;
    bus.host_req = h_pend; bus.host_we = h_w; bus.host_addr = h_a; bus.host_wdata = h_d;
    eh = h_pend && (!v_pend || m_wait >= STARVE_MAX);
    ev = v_pend && !eh;
    e = prev_cmd;
    e.vg = ev; e.hg = eh; e.st = eh && v_pend; e.zero = 0;
    exp_q.push_back(e);
    prev_cmd.en    = ev || eh;
    prev_cmd.we    = eh && h_w;
    prev_cmd.addr  = eh ? h_a : v_a;
    prev_cmd.wdata = eh ? h_d : '0;
    if (eh || !h_pend) m_wait = 0;
    else if (m_wait < STARVE_MAX) m_wait++;
    if (ev) begin
      rd_q.push_back('{host: 1'b0, data: mread(v_a), due: cyc + MEM_LAT + 2});
      v_pend = 1'b0;
    end
    if (eh) begin
      if (h_w) m_mem[int'(h_a)] = h_d;
      else rd_q.push_back('{host: 1'b1, data: mread(h_a), due: cyc + MEM_LAT + 2});
      h_pend = 1'b0;
    end
  endtask

  task automatic reset_cycles(input int n);
    cyc_exp_t e;
    repeat (n) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.vga_req = 0; bus.host_req = 0;
      rd_q.delete();
      v_pend = 0; h_pend = 0; m_wait = 0;
      clear_cmd();
      e = prev_cmd;
      e.zero = 1;
      exp_q.push_back(e);
    end
  endtask

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    cyc_exp_t e;
    rd_exp_t  r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("vga_gnt", 32'(bus.vga_gnt), 32'(e.vg));
      cmp("host_gnt", 32'(bus.host_gnt), 32'(e.hg));
      cmp("host_starved", 32'(bus.host_starved), 32'(e.st));
      cmp("mem_en", 32'(bus.mem_en), 32'(e.en));
      if (e.en) begin
        cmp("mem_we", 32'(bus.mem_we), 32'(e.we));
        cmp("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        cmp("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
      end
      if (e.zero) begin
        cmp("reset_vga_rdata", 32'(bus.vga_rdata), 32'd0);
        cmp("reset_host_rdata", 32'(bus.host_rdata), 32'd0);
        cmp("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        cmp("reset_mem_we", 32'(bus.mem_we), 32'd0);
      end
    end
    if (bus.vga_rvalid || bus.host_rvalid) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid at cycle %0d: vga_rvalid=%0b host_rvalid=%0b, expected none",
                 cyc, bus.vga_rvalid, bus.host_rvalid);
      end else begin
        r = rd_q.pop_front();
        cmp("rvalid_port", 32'({bus.host_rvalid, bus.vga_rvalid}), r.host ? 32'd2 : 32'd1);
        cmp("rvalid_cycle", 32'(cyc), 32'(r.due));
        cmp("rdata", r.host ? 32'(bus.host_rdata) : 32'(bus.vga_rdata), 32'(r.data));
      end
    end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      r = rd_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_rvalid at cycle %0d: no rvalid, expected %s data 0x%0h due cycle %0d",
               cyc, r.host ? "host" : "vga", r.data, r.due);
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.vga_req = 0; bus.vga_addr = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    v_pend = 0; h_pend = 0; h_w = 0; v_a = '0; h_a = '0; h_d = '0; m_wait = 0;
    clear_cmd();

    reset_cycles(3);
    repeat (10) tick();

    arm_v(17'h00010);
    repeat (6) tick();

    arm_h(1'b1, 17'h1FFFF, 12'h123);
    tick();
    arm_h(1'b0, 17'h1FFFF, 12'h000);
    repeat (7) tick();

    for (int i = 0; i < 20; i++) begin
      if (!v_pend) arm_v(r_addr());
      if (!h_pend) arm_h(1'b0, r_addr(), '0);
      tick();
    end
    repeat (8) tick();

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        if (!v_pend) arm_v(r_addr());
      end else begin
        if (!h_pend) arm_h(1'b0, r_addr(), '0);
      end
      tick();
    end
    repeat (8) tick();

    for (int i = 0; i < 3; i++) begin
      arm_v(r_addr());
      tick();
    end
    reset_cycles(2);
    arm_v(17'h00010);
    repeat (8) tick();

    repeat (300) begin
      if (!v_pend && $urandom_range(0, 3) != 0) arm_v(r_addr());
      if (!h_pend && $urandom_range(0, 2) == 0)
        arm_h(1'($urandom_range(0, 1)), r_addr(), DW'($urandom_range(0, 4095)));
      tick();
    end
    repeat (12) tick();

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters.
- VGA scan-out pixel fetch: read-only, has a display deadline, normally wins arbitration.
- Host (UART command path) port: read/write.
- Registers the RAM command, tracks in-flight reads with a tag pipeline, and routes read data back to the issuing requester.
- Sits between the vga timing/pixel logic and the framebuffer RAM in top, all on vga_clk.

Parameters:
- AW, 17, address width (320x240 = 76800 words fits).
- DW, 12, data width (4-bit R, G, B packed {r,g,b}).
- MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata (legal 1..4).
- STARVE_MAX, 4, consecutive cycles a waiting host may be denied before it is forced a grant (legal >=1).

Ports:
- clk  in  1  vga_clk domain
- rst_n  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA read request
- vga_addr  in  AW  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rdata  out  DW  VGA read data
- vga_rvalid  out  1  vga_rdata valid (1-cycle pulse per accepted read)
- host_req  in  1  host request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rdata  out  DW  host read data
- host_rvalid  out  1  host_rdata valid (reads only)
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid MEM_LAT cycles after mem_en
- host_starved  out  1  1-cycle pulse when a forced host grant preempts a VGA request

Behaviour:
- Reset: all outputs 0, starve_cnt = 0, tag pipeline cleared. Reset is asynchronous on assertion; deassertion is used synchronously.
- Grants are combinational from the req inputs and starve_cnt. At most one grant per cycle. A requester holds req, addr (and we, wdata for host) stable until its gnt; the transfer occurs in the cycle req && gnt.
- Arbitration:
  - vga_gnt = vga_req && !(host_req && starve_cnt == STARVE_MAX).
  - host_gnt = host_req && (!vga_req || starve_cnt == STARVE_MAX).
  - Neither requesting: no grant, mem_en = 0 next cycle.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Cleared when host_gnt or !host_req.
  - Increments (saturating at STARVE_MAX) when host_req && !host_gnt.
  - host_starved pulses in any cycle where host_gnt && vga_req.
- Command stage: in grant cycle T, the RAM command is registered. At T+1: mem_en = 1, mem_addr, mem_we (= host_we for host, 0 for VGA), mem_wdata (host_wdata for host, 0 for VGA).
- Tag pipeline: a 2-bit tag {NONE, VGA, HOST} enters at T+1 for reads only (host writes enter NONE). It is delayed MEM_LAT cycles so it aligns with mem_rdata at T+1+MEM_LAT.
- Return stage: at T+1+MEM_LAT, mem_rdata is registered into vga_rdata or host_rdata per tag. The matching rvalid pulses at T+2+MEM_LAT. Total read latency = MEM_LAT+2 cycles; it is fixed, independent of contention.
- rdata registers hold their last value when rvalid = 0.
- Back-to-back grants are allowed every cycle with full throughput. Returns are strictly in grant order.
- Host write followed next cycle by a host or VGA read of the same address returns the new data (RAM ordering; no forwarding in this block).
- Reset mid-operation: in-flight reads are dropped; no rvalid pulses after rst_n deasserts for accesses granted before reset.
- Simultaneous requests with starve_cnt < STARVE_MAX: VGA wins and starve_cnt increments.

Decomposition:
- Package fb_arb_pkg:
  - Enum req_tag_t {TAG_NONE = 2'd0, TAG_VGA = 2'd1, TAG_HOST = 2'd2}.
  - Default constants FB_AW = 17, FB_DW = 12.
- Sub-module fb_arb_tag_pipe: parameterised MEM_LAT-deep shift register of req_tag_t with async active-low clear.

Test Plan:
- Single VGA read: vga_req at addr 0x00010, RAM holds 0xABC, MEM_LAT = 1 -> vga_gnt the same cycle; mem_en/mem_addr = 0x00010 one cycle later; vga_rvalid with 0xABC 3 cycles after the grant; host outputs stay 0.
- Host write then read: write 0x123 to 0x1FFFF, then read 0x1FFFF -> mem_we = 1 only on the first command; exactly one host_rvalid with 0x123 at grant+3; no rvalid for the write.
- Starvation guard: vga_req held high for 20 cycles, host_req high from cycle 0 with STARVE_MAX = 4 -> host_gnt and host_starved at cycle 4; VGA granted in every other cycle; host held again -> next forced grant at cycle 9.
- Throughput and ordering: alternate VGA and host reads for 16 cycles with MEM_LAT = 3 -> one mem_en per cycle; rvalids arrive in grant order at grant+5 with correct per-port data.
- Reset mid-flight: assert rst_n low one cycle after 3 reads are granted -> all outputs 0 immediately; no rvalid after release; first new read returns normally.
- Idle: no requests for 10 cycles -> mem_en, both gnt and both rvalid stay 0; starve_cnt stays 0.
